// File: rtl/uart_rx_pkg.sv
// Shared UART receive-path constants used by the control, shift-register and FIFO stages.
package uart_rx_pkg;
    localparam int          DATA_W    = 8;
    localparam logic [7:0]  IDLE_BYTE = 8'hFF;
endpackage

// File: rtl/rx_ptr_ctr.sv
// Free-running circular pointer; width sets the ring size so wrap is the natural overflow.
module rx_ptr_ctr #(
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             en,
    output logic [PTR_W-1:0] ptr
);
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            ptr <= '0;
        else if (en)
            ptr <= ptr + 1'b1;
    end
endmodule

// File: rtl/rx_fifo_buffer.sv
// Receive byte FIFO between the UART receiver and its consumer, with a sticky overrun flag.
module rx_fifo_buffer
    import uart_rx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     load_buffer,
    input  logic [DATA_W-1:0]        packet_data,
    input  logic                     data_read,
    output logic [DATA_W-1:0]        rx_data,
    output logic                     data_ready,
    output logic                     overrun_error,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic              full;
    logic              empty;
    logic              push_ok;
    logic              pop_ok;
    logic              drop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A pop on a full queue frees the slot the same edge, so the push still lands.
    assign pop_ok  = data_read && !empty;
    assign push_ok = load_buffer && (!full || pop_ok);
    assign drop    = load_buffer && !push_ok;

    rx_ptr_ctr #(.PTR_W(PTR_W)) u_wptr (
        .clk   (clk),
        .n_rst (n_rst),
        .en    (push_ok),
        .ptr   (wptr)
    );

    rx_ptr_ctr #(.PTR_W(PTR_W)) u_rptr (
        .clk   (clk),
        .n_rst (n_rst),
        .en    (pop_ok),
        .ptr   (rptr)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= IDLE_BYTE;
        end else if (push_ok) begin
            mem[wptr] <= packet_data;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Setting wins over clearing when a drop and an accepted pop share an edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            overrun_error <= 1'b0;
        else if (drop)
            overrun_error <= 1'b1;
        else if (pop_ok)
            overrun_error <= 1'b0;
    end

    assign data_ready = !empty;
    assign rx_data    = empty ? IDLE_BYTE : mem[rptr];
endmodule

// File: tb/tb_rx_fifo_buffer.sv
// Self-checking bench for rx_fifo_buffer: directed scenarios plus random traffic against a queue model.
module tb_rx_fifo_buffer;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int SW    = CW + 10;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          load_buffer = 1'b0;
    logic [7:0]    packet_data = 8'h00;
    logic          data_read = 1'b0;
    logic [7:0]    rx_data;
    logic          data_ready;
    logic          overrun_error;
    logic [CW-1:0] count;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    logic       m_ovr = 1'b0;

    rx_fifo_buffer #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .load_buffer   (load_buffer),
        .packet_data   (packet_data),
        .data_read     (data_read),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .overrun_error (overrun_error),
        .count         (count)
    );

    always #5 clk = ~clk;

    function automatic logic [SW-1:0] exp_state();
        logic [7:0] head;
        head = (q.size() != 0) ? q[0] : 8'hFF;
        return {CW'(q.size()), q.size() != 0, head, m_ovr};
    endfunction

    function automatic logic [SW-1:0] dut_state();
        return {count, data_ready, rx_data, overrun_error};
    endfunction

    // Queue model: a pop needs a stored byte, a push needs room (or a same-edge pop).
    task automatic model_edge(input logic lb, input logic [7:0] pd, input logic dr);
        bit pop_ok, push_ok;
        pop_ok  = dr && (q.size() > 0);
        push_ok = lb && ((q.size() < DEPTH) || pop_ok);
        if (pop_ok)  void'(q.pop_front());
        if (push_ok) q.push_back(pd);
        if (lb && !push_ok) m_ovr = 1'b1;
        else if (pop_ok)    m_ovr = 1'b0;
    endtask

    task automatic cyc(input logic lb, input logic [7:0] pd, input logic dr);
        @(negedge clk);
        load_buffer = lb;
        packet_data = pd;
        data_read   = dr;
        @(posedge clk);
        model_edge(lb, pd, dr);
        #1;
        load_buffer = 1'b0;
        data_read   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_rst = 1'b0;
        q.delete();
        m_ovr = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (dut_state() !== {CW'(0), 1'b0, 8'hFF, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got=%h want=%h", dut_state(), {CW'(0), 1'b0, 8'hFF, 1'b0});
        end
    endtask

    task automatic test_single();
        cyc(1'b1, 8'hA5, 1'b0);
        checks++;
        if ({count, data_ready, rx_data} !== {CW'(1), 1'b1, 8'hA5}) begin
            errors++;
            $display("FAIL single_push got cnt=%0d rdy=%b data=%h want 1/1/a5", count, data_ready, rx_data);
        end
        cyc(1'b0, 8'h00, 1'b1);
        checks++;
        if ({data_ready, rx_data} !== {1'b0, 8'hFF}) begin
            errors++;
            $display("FAIL single_pop got rdy=%b data=%h want 0/ff", data_ready, rx_data);
        end
    endtask

    task automatic test_overrun();
        for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(i), 1'b0);
        checks++;
        if (count !== CW'(4) || overrun_error !== 1'b0) begin
            errors++;
            $display("FAIL fill_count got cnt=%0d ovr=%b want 4/0", count, overrun_error);
        end
        cyc(1'b1, 8'h05, 1'b0);
        checks++;
        if (count !== CW'(4) || overrun_error !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set got cnt=%0d ovr=%b want 4/1", count, overrun_error);
        end
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (rx_data !== 8'(i)) begin
                errors++;
                $display("FAIL overrun_pop%0d got=%h want=%h", i, rx_data, 8'(i));
            end
            cyc(1'b0, 8'h00, 1'b1);
            checks++;
            if (overrun_error !== 1'b0) begin
                errors++;
                $display("FAIL overrun_clear%0d got=%b want=0", i, overrun_error);
            end
        end
    endtask

    task automatic test_full_simul();
        logic [7:0] want [4] = '{8'h02, 8'h03, 8'h04, 8'h55};
        for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(i), 1'b0);
        cyc(1'b1, 8'h55, 1'b1);
        checks++;
        if (count !== CW'(4) || overrun_error !== 1'b0) begin
            errors++;
            $display("FAIL full_simul got cnt=%0d ovr=%b want 4/0", count, overrun_error);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rx_data !== want[i]) begin
                errors++;
                $display("FAIL full_simul_pop%0d got=%h want=%h", i, rx_data, want[i]);
            end
            cyc(1'b0, 8'h00, 1'b1);
        end
        checks++;
        if (dut_state() !== exp_state()) begin
            errors++;
            $display("FAIL full_simul_end got=%h want=%h", dut_state(), exp_state());
        end
    endtask

    task automatic test_empty_simul();
        cyc(1'b1, 8'h3C, 1'b1);
        checks++;
        if ({count, rx_data, overrun_error} !== {CW'(1), 8'h3C, 1'b0}) begin
            errors++;
            $display("FAIL empty_simul got cnt=%0d data=%h ovr=%b want 1/3c/0", count, rx_data, overrun_error);
        end
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        checks++;
        if (dut_state() !== {CW'(0), 1'b0, 8'hFF, 1'b0}) begin
            errors++;
            $display("FAIL empty_read got=%h want=%h", dut_state(), {CW'(0), 1'b0, 8'hFF, 1'b0});
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 8'h10 + 8'(i), 1'b0);
            checks++;
            if (rx_data !== 8'h10 + 8'(i) || overrun_error !== 1'b0) begin
                errors++;
                $display("FAIL wrap%0d got data=%h ovr=%b want %h/0", i, rx_data, overrun_error, 8'h10 + 8'(i));
            end
            cyc(1'b0, 8'h00, 1'b1);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            cyc(1'($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom_range(0, 99) < 45));
            checks++;
            if (dut_state() !== exp_state()) begin
                errors++;
                $display("FAIL random%0d got=%h want=%h", n, dut_state(), exp_state());
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'hC0 + 8'(i), 1'b0);
        @(negedge clk);
        #2;
        n_rst = 1'b0;
        q.delete();
        m_ovr = 1'b0;
        #1;
        checks++;
        if (dut_state() !== {CW'(0), 1'b0, 8'hFF, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got=%h want=%h", dut_state(), {CW'(0), 1'b0, 8'hFF, 1'b0});
        end
        @(negedge clk);
        n_rst = 1'b1;
        cyc(1'b1, 8'h77, 1'b0);
        checks++;
        if ({count, rx_data} !== {CW'(1), 8'h77}) begin
            errors++;
            $display("FAIL post_reset_push got cnt=%0d data=%h want 1/77", count, rx_data);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overrun();
        test_full_simul();
        test_empty_simul();
        test_wrap();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
